processor_data_memory: RTL and testbench

- Responder side of the stage-2 data memory interface. Services `memory_addr` / `memory_write_enable` / `memory_in` issued by the pipeline (loads, stores, call pushes) and returns registered read data.
- Contains the data RAM plus a small memory-mapped I/O window with three functions:
  - a free-running cycle counter;
  - a byte-wide TX FIFO with a valid/ready drain port;
  - a wake timer that releases the processor from a `wait` instruction.

---
 rtl/processor_data_memory.sv | 198 +++++++++++++++++++
 tb/tb_processor_data_memory.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_data_memory.sv
`default_nettype none
// ============================================================================
//  Module   : processor_data_memory
//  Purpose  : Stage-2 data memory responder. Contains the data RAM and a
//             16-word I/O window: a free-running cycle counter, a byte TX
//             FIFO with a valid/ready drain port, and a wake timer that
//             releases the processor from a wait.
//  Option   : DMEM_BOUNDS_TRAP_EN - sticky bus_error on unmapped accesses
//             and on writes to the read-only I/O offsets 4-15.
//  Revision : 1.0 - initial release
// ============================================================================
module processor_data_memory #(
   parameter int unsigned          ADDR_SIZE  = 18,
   parameter int unsigned          WORD_SIZE  = 18,
   parameter int unsigned          RAM_WORDS  = 1024,
   parameter logic [ADDR_SIZE-1:0] IO_BASE    = 18'h3FFF0,
   parameter int unsigned          FIFO_DEPTH = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [ADDR_SIZE-1:0] memory_addr,
   input  logic                 memory_write_enable,
   input  logic [WORD_SIZE-1:0] memory_in,
   output logic [WORD_SIZE-1:0] memory_out,
   input  logic                 waiting,
   output logic                 wake,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 bus_error
);

   localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
   localparam int unsigned FIFO_LOG2 = $clog2(FIFO_DEPTH);
   // Decode limits carry one extra bit so IO_BASE+16 cannot wrap to zero.
   localparam logic [ADDR_SIZE:0] RAM_END = (ADDR_SIZE+1)'(RAM_WORDS);
   localparam logic [ADDR_SIZE:0] IO_LO   = {1'b0, IO_BASE};
   localparam logic [ADDR_SIZE:0] IO_HI   = IO_LO + (ADDR_SIZE+1)'(16);

   // ---------------------------------------------------------------- decode
   logic                 w_is_ram;
   logic                 w_is_io;
   logic [3:0]           w_off;
   logic                 w_io_wr;
   logic [RAM_AW-1:0]    w_ram_idx;

   assign w_is_ram  = ({1'b0, memory_addr} < RAM_END);
   assign w_is_io   = ({1'b0, memory_addr} >= IO_LO) && ({1'b0, memory_addr} < IO_HI);
   assign w_off     = memory_addr[3:0];
   assign w_io_wr   = memory_write_enable && w_is_io;
   assign w_ram_idx = memory_addr[RAM_AW-1:0];

   // ---------------------------------------------------------------- state
   logic [WORD_SIZE-1:0] ram_q [RAM_WORDS];
   logic [7:0]           fifo_q [FIFO_DEPTH];

   logic [WORD_SIZE-1:0] rd_q, rd_d;
   logic [WORD_SIZE-1:0] cnt_q, cnt_d;
   logic [WORD_SIZE-1:0] timer_q, timer_d;
   logic                 pend_q, pend_d;
   logic                 wake_q, wake_d;
   logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_LOG2:0]   count_q, count_d;
   logic                 ovf_q, ovf_d;

   logic                 w_full, w_empty, w_pop, w_push_req, w_push, w_expire;
   logic [WORD_SIZE-1:0] w_status;

   assign w_full     = (count_q == (FIFO_LOG2+1)'(FIFO_DEPTH));
   assign w_empty    = (count_q == '0);
   assign w_pop      = !w_empty && tx_ready;
   assign w_push_req = w_io_wr && (w_off == 4'd1);
   // A simultaneous pop frees the slot a full FIFO needs for the push.
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_status   = WORD_SIZE'({ovf_q, w_full, w_empty, count_q});

   // RAM write port; contents deliberately survive reset.
   always_ff @(posedge clock) begin
      if (memory_write_enable && w_is_ram)
         ram_q[w_ram_idx] <= memory_in;
   end

   // FIFO storage; only the pointers are reset, which discards the contents.
   always_ff @(posedge clock) begin
      if (w_push)
         fifo_q[wr_ptr_q] <= memory_in[7:0];
   end

   // Read mux: RAM, I/O registers, or zero for everything else.
   always_comb begin
      rd_d = '0;
      if (w_is_ram) begin
         rd_d = ram_q[w_ram_idx];
      end else if (w_is_io) begin
         case (w_off)
            4'd0:    rd_d = cnt_q;
            4'd1:    rd_d = w_status;
            4'd2:    rd_d = timer_q;
            default: rd_d = '0;
         endcase
      end
   end

   // Cycle counter: free running, loadable through offset 0.
   always_comb begin
      cnt_d = cnt_q + WORD_SIZE'(1);
      if (w_io_wr && (w_off == 4'd0))
         cnt_d = memory_in;
   end

   // FIFO pointers, occupancy and sticky overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (w_push)
         wr_ptr_d = wr_ptr_q + FIFO_LOG2'(1);
      if (w_pop)
         rd_ptr_d = rd_ptr_q + FIFO_LOG2'(1);
      if (w_push && !w_pop)
         count_d = count_q + (FIFO_LOG2+1)'(1);
      else if (!w_push && w_pop)
         count_d = count_q - (FIFO_LOG2+1)'(1);
      if (w_push_req && !w_push)
         ovf_d = 1'b1;
      if (w_io_wr && (w_off == 4'd3))
         ovf_d = 1'b0;
   end

   // Wake timer: an expiry is consumed at once if the core is already
   // waiting, otherwise it is parked in pend_q until waiting rises.
   always_comb begin
      timer_d  = timer_q;
      w_expire = 1'b0;
      if (w_io_wr && (w_off == 4'd2)) begin
         timer_d  = memory_in;
         w_expire = (memory_in == '0);
      end else if (timer_q != '0) begin
         timer_d  = timer_q - WORD_SIZE'(1);
         w_expire = (timer_q == WORD_SIZE'(1));
      end
      wake_d = (pend_q || w_expire) && waiting;
      pend_d = (pend_q || w_expire) && !waiting;
   end

   // Register bank for all resettable state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_q     <= '0;
         cnt_q    <= '0;
         timer_q  <= '0;
         pend_q   <= 1'b0;
         wake_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         timer_q  <= timer_d;
         pend_q   <= pend_d;
         wake_q   <= wake_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   assign memory_out = rd_q;
   assign wake       = wake_q;
   assign tx_data    = fifo_q[rd_ptr_q];
   assign tx_valid   = !w_empty;

`ifdef DMEM_BOUNDS_TRAP_EN
   logic berr_q;
   logic w_fault;

   assign w_fault = (!w_is_ram && !w_is_io) || (w_io_wr && (w_off >= 4'd4));

   // Sticky access-fault flag, cleared only by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         berr_q <= 1'b0;
      else if (w_fault)
         berr_q <= 1'b1;
   end

   assign bus_error = berr_q;
`else
   assign bus_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_processor_data_memory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_processor_data_memory
//  Purpose  : Self-checking bench for processor_data_memory: directed vector
//             table, hand-written FIFO / wake / reset sequences, and random
//             traffic compared against a queue-based behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_processor_data_memory;

   localparam logic [17:0] IO = 18'h3FFF0;
`ifdef DMEM_BOUNDS_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [17:0] memory_addr = '0;
   logic        memory_write_enable = 1'b0;
   logic [17:0] memory_in = '0;
   logic [17:0] memory_out;
   logic        waiting = 1'b0;
   logic        wake;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        bus_error;

   always #5 clock = ~clock;

   processor_data_memory dut (
      .clock               (clock),
      .reset               (reset),
      .memory_addr         (memory_addr),
      .memory_write_enable (memory_write_enable),
      .memory_in           (memory_in),
      .memory_out          (memory_out),
      .waiting             (waiting),
      .wake                (wake),
      .tx_data             (tx_data),
      .tx_valid            (tx_valid),
      .tx_ready            (tx_ready),
      .bus_error           (bus_error)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // ------------------------------------------------------- reference model
   logic [17:0] m_ram [1024];
   bit          m_ram_ok [1024];
   logic [7:0]  m_q [$];
   logic [17:0] m_cnt, m_timer, m_out;
   bit          m_ovf, m_pend, m_wake, m_berr, m_out_ok;

   task automatic model_reset();
      m_cnt = 0; m_timer = 0; m_out = 0; m_out_ok = 1;
      m_ovf = 0; m_pend = 0; m_wake = 0; m_berr = 0;
      m_q.delete();
   endtask

   function automatic logic [17:0] m_status();
      int n = m_q.size();
      return 18'({m_ovf, n == 4, n == 0, 3'(n)});
   endfunction

   // Advance the model across one rising edge using the current inputs.
   task automatic model_edge();
      logic [17:0] a = memory_addr;
      bit ram = (a < 18'd1024);
      bit io  = (a >= IO);
      int off = int'(a[3:0]);
      bit wr  = memory_write_enable;
      bit expire = 0;
      m_out = 0; m_out_ok = 1;
      if (ram) begin m_out = m_ram[a[9:0]]; m_out_ok = m_ram_ok[a[9:0]]; end
      else if (io) begin
         if (off == 0) m_out = m_cnt;
         else if (off == 1) m_out = m_status();
         else if (off == 2) m_out = m_timer;
      end
      if (TRAP && ((!ram && !io) || (wr && io && off >= 4))) m_berr = 1;
      if (m_q.size() > 0 && tx_ready) void'(m_q.pop_front());
      if (wr && io && off == 1) begin
         if (m_q.size() < 4) m_q.push_back(memory_in[7:0]);
         else m_ovf = 1;
      end
      if (wr && io && off == 3) m_ovf = 0;
      m_cnt = (wr && io && off == 0) ? memory_in : m_cnt + 18'd1;
      if (wr && io && off == 2) begin
         m_timer = memory_in; expire = (memory_in == 0);
      end else if (m_timer != 0) begin
         m_timer = m_timer - 18'd1; expire = (m_timer == 0);
      end
      m_pend = m_pend | expire;
      m_wake = m_pend && waiting;
      if (m_wake) m_pend = 0;
      if (wr && ram) begin m_ram[a[9:0]] = memory_in; m_ram_ok[a[9:0]] = 1; end
   endtask

   // One clock with lockstep comparison of every output against the model.
   task automatic cycle();
      model_edge();
      @(posedge clock); #1;
      if (m_out_ok) check("memory_out", 32'(memory_out), 32'(m_out));
      check("wake", 32'(wake), 32'(m_wake));
      check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("tx_data", 32'(tx_data), 32'(m_q[0]));
      check("bus_error", 32'(bus_error), 32'(m_berr));
   endtask

   task automatic drive(input logic [17:0] a, input bit we, input logic [17:0] d);
      memory_addr = a; memory_write_enable = we; memory_in = d;
   endtask

   task automatic do_reset();
      drive(IO + 18'd4, 1'b0, '0);
      reset = 1'b0;
      model_reset();
      @(posedge clock); #1;
      reset = 1'b1;
   endtask

   typedef struct {
      logic [17:0] addr;
      bit          we;
      logic [17:0] din;
      bit          chk;
      logic [17:0] exp;
   } vec_t;

   vec_t       vt [14];
   logic [7:0] exp4 [4];

   initial begin
      for (int i = 0; i < 1024; i++) m_ram_ok[i] = 0;
      model_reset();

      // Reset state
      @(posedge clock); #1;
      check("rst_memory_out", 32'(memory_out), 32'h0);
      check("rst_wake", 32'(wake), 32'h0);
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check("rst_bus_error", 32'(bus_error), 32'h0);
      reset = 1'b1;

      // Directed vectors: RAM round trip, read-first, decode boundaries
      vt[0]  = '{18'd5,       1'b1, 18'h2A5A5, 1'b0, 18'h0};
      vt[1]  = '{18'd5,       1'b0, 18'h0,     1'b1, 18'h2A5A5};
      vt[2]  = '{18'd5,       1'b1, 18'd7,     1'b1, 18'h2A5A5};
      vt[3]  = '{18'd5,       1'b0, 18'h0,     1'b1, 18'd7};
      vt[4]  = '{18'h20000,   1'b0, 18'h0,     1'b1, 18'h0};
      vt[5]  = '{18'h20000,   1'b1, 18'd3,     1'b1, 18'h0};
      vt[6]  = '{18'h20000,   1'b0, 18'h0,     1'b1, 18'h0};
      vt[7]  = '{18'd1023,    1'b1, 18'h1234,  1'b0, 18'h0};
      vt[8]  = '{18'd1023,    1'b0, 18'h0,     1'b1, 18'h1234};
      vt[9]  = '{18'd1024,    1'b0, 18'h0,     1'b1, 18'h0};
      vt[10] = '{18'h3FFEF,   1'b0, 18'h0,     1'b1, 18'h0};
      vt[11] = '{18'h3FFF3,   1'b0, 18'h0,     1'b1, 18'h0};
      vt[12] = '{18'h3FFF5,   1'b1, 18'h111,   1'b1, 18'h0};
      vt[13] = '{18'h3FFF5,   1'b0, 18'h0,     1'b1, 18'h0};
      for (int i = 0; i < 14; i++) begin
         drive(vt[i].addr, vt[i].we, vt[i].din);
         cycle();
         if (vt[i].chk) check($sformatf("vec%0d", i), 32'(memory_out), 32'(vt[i].exp));
      end
      check("bus_error_sticky", 32'(bus_error), 32'(TRAP));

      // Wake with waiting=1: write 3, pulse exactly on the third edge after
      waiting = 1'b1;
      drive(IO + 18'd2, 1'b1, 18'd3);
      cycle();
      check("wake_at_write", 32'(wake), 32'h0);
      drive(IO + 18'd4, 1'b0, '0);
      for (int i = 1; i <= 5; i++) begin
         cycle();
         check($sformatf("wake_t%0d", i), 32'(wake), 32'(i == 3));
      end

      // Wake with waiting=0 at expiry: held pending until waiting rises
      waiting = 1'b0;
      drive(IO + 18'd2, 1'b1, 18'd2);
      cycle();
      drive(IO + 18'd4, 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("wake_held", 32'(wake), 32'h0);
      end
      waiting = 1'b1;
      cycle();
      check("wake_after_waiting", 32'(wake), 32'h1);
      cycle();
      check("wake_one_shot", 32'(wake), 32'h0);
      waiting = 1'b0;

      // FIFO overflow and in-order drain
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(IO + 18'd1, 1'b1, 18'h41 + 18'(i));
         cycle();
      end
      drive(IO + 18'd1, 1'b0, '0);
      cycle();
      check("status_full_ovf", 32'(memory_out), 32'h34);
      drive(IO + 18'd4, 1'b0, '0);
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_valid", 32'(tx_valid), 32'h1);
         check("drain_data", 32'(tx_data), 32'h41 + 32'(i));
         cycle();
      end
      check("drain_empty", 32'(tx_valid), 32'h0);
      tx_ready = 1'b0;
      drive(IO + 18'd3, 1'b1, 18'h0);
      cycle();
      drive(IO + 18'd1, 1'b0, '0);
      cycle();
      check("status_ovf_clear", 32'(memory_out), 32'h08);

      // Full FIFO: push and pop in the same cycle
      for (int i = 0; i < 4; i++) begin
         drive(IO + 18'd1, 1'b1, 18'h61 + 18'(i));
         cycle();
      end
      tx_ready = 1'b1;
      drive(IO + 18'd1, 1'b1, 18'h55);
      cycle();
      tx_ready = 1'b0;
      drive(IO + 18'd1, 1'b0, '0);
      cycle();
      check("status_full_pushpop", 32'(memory_out), 32'h14);
      exp4[0] = 8'h62; exp4[1] = 8'h63; exp4[2] = 8'h64; exp4[3] = 8'h55;
      drive(IO + 18'd4, 1'b0, '0);
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("pushpop_data", 32'(tx_data), 32'(exp4[i]));
         cycle();
      end
      check("pushpop_empty", 32'(tx_valid), 32'h0);

      // Empty FIFO: push with tx_ready high stores the byte
      drive(IO + 18'd1, 1'b1, 18'h77);
      cycle();
      check("empty_push_valid", 32'(tx_valid), 32'h1);
      check("empty_push_data", 32'(tx_data), 32'h77);
      drive(IO + 18'd4, 1'b0, '0);
      cycle();
      check("empty_push_drained", 32'(tx_valid), 32'h0);

      // Randomised traffic against the model
      for (int i = 0; i < 1500; i++) begin
         int unsigned sel = $urandom_range(0, 9);
         logic [17:0] a;
         logic [17:0] d;
         if (sel <= 3)      a = 18'($urandom_range(0, 15));
         else if (sel == 4) a = 18'($urandom_range(1008, 1023));
         else if (sel <= 7) a = IO + 18'($urandom_range(0, 4));
         else if (sel == 8) a = IO + 18'($urandom_range(5, 15));
         else               a = 18'($urandom);
         d = 18'($urandom);
         if (a == IO + 18'd2) d = 18'($urandom_range(0, 6));
         drive(a, ($urandom_range(0, 2) == 0), d);
         tx_ready = ($urandom_range(0, 3) == 0);
         waiting  = ($urandom_range(0, 1) == 1);
         cycle();
      end

      // Reset mid-operation: two bytes queued, timer at 10
      tx_ready = 1'b0;
      waiting  = 1'b0;
      do_reset();
      drive(IO + 18'd1, 1'b1, 18'h11); cycle();
      drive(IO + 18'd1, 1'b1, 18'h22); cycle();
      drive(IO + 18'd2, 1'b1, 18'd10); cycle();
      drive(IO + 18'd4, 1'b0, '0);
      check("pre_reset_valid", 32'(tx_valid), 32'h1);
      reset = 1'b0;
      model_reset();
      #2;
      check("midrst_tx_valid", 32'(tx_valid), 32'h0);
      check("midrst_memory_out", 32'(memory_out), 32'h0);
      @(posedge clock); #1;
      reset = 1'b1;
      waiting = 1'b1;
      drive(IO, 1'b0, '0);
      cycle();
      check("counter_restart", 32'(memory_out), 32'h0);
      cycle();
      check("counter_second", 32'(memory_out), 32'h1);
      drive(IO + 18'd4, 1'b0, '0);
      for (int i = 0; i < 15; i++) begin
         cycle();
         check("no_wake_after_reset", 32'(wake), 32'h0);
      end
      check("post_reset_empty", 32'(tx_valid), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
